// File: rtl/mcac_pkg.sv
// Shared constants and types for the signal-estimate accumulator feed path.
//   WORD_W : serial word width (one accumulator circulation)
//   NPROD  : partial products per sample frame
//   NZERO  : zero-predictor products (SEZI is captured after these)
//   state_e: feed sequencer FSM states
package mcac_pkg;

    localparam int WORD_W = 16;
    localparam int NPROD  = 8;
    localparam int NZERO  = 6;
    localparam int PH_W   = 4;
    localparam int K_W    = 3;

    localparam logic [PH_W-1:0] PH_LAST   = 4'd15;
    localparam logic [K_W-1:0]  K_SEZI    = 3'(NZERO - 1);
    localparam logic [K_W-1:0]  K_SEI     = 3'(NPROD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/accum_seq_p2s16.sv
// 16-bit parallel-load, LSB-first shift register.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (clears the register)
//   load_i  : load data_i (wins over shift_i)
//   shift_i : shift right by one, zero fill
//   data_i  : parallel word
//   bit_o   : current LSB (registered)
// Zero fill means a fully shifted-out word leaves the output at 0, which is
// exactly the idle level the accumulator needs between products.
module p2s16
    import mcac_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              bit_o
);

    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = {1'b0, data_q[WORD_W-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bit_o = data_q[0];

endmodule

// File: rtl/accum_seq.sv
// Bit-serial feed sequencer for the signal-estimate accumulator.
// Accepts eight 16-bit products per frame and serialises each LSB-first on
// 'a', driving the accumulator's clear (m1_sel/m2_sel) and capture strobes.
//   clk        : clock          reset      : sync active-high reset
//   start      : frame request (honoured in IDLE only)
//   prod       : partial product     prod_valid/prod_ready : handshake
//   a          : serial product bit  m1_sel : zero accumulator carry input
//   m2_sel     : zero accumulator shift-register input
//   sezi_en    : SEZI capture strobe (negedge flop)
//   sei_en     : SEI capture strobe (negedge flop)
//   busy       : frame in progress   done   : end-of-frame pulse
//   dbg_state  : current FSM state
//
// Handshake: a product transfers on a rising clk edge where prod_valid and
// prod_ready are both 1. prod_ready only rises in phase 15, so every product
// starts shifting at phase 0 and stays aligned with the accumulator word.
module accum_seq
    import mcac_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic              a,
    output logic              m1_sel,
    output logic              m2_sel,
    output logic              sezi_en,
    output logic              sei_en,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [K_W-1:0]  k_q, k_d;
    logic            pend_q, pend_d;
    logic            sezi_sched_q, sezi_sched_d;
    logic            sei_sched_q, sei_sched_d;
    logic            m1_q, m1_d;
    logic            m2_q, m2_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sezi_q, sei_q;

    logic            accept;
    logic            last;
    logic            last_n;
    logic            sr_load;
    logic            sr_shift;

    assign accept = prod_valid & ready_q;
    assign last   = (phase_q == PH_LAST);

    // Next state, product counter and shift-register control.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        pend_d       = pend_q;
        sezi_sched_d = 1'b0;
        sei_sched_d  = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A request is held until the word boundary so CLEAR covers
                // exactly one aligned circulation.
                if (start || pend_q) begin
                    if (last) begin
                        state_d = ST_CLEAR;
                        pend_d  = 1'b0;
                    end else begin
                        pend_d  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (last) begin
                    k_d = '0;
                    if (accept) begin
                        sr_load = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    sr_load = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_shift = 1'b1;
                if (last) begin
                    if (k_q == K_SEZI) begin
                        sezi_sched_d = 1'b1;
                    end
                    if (k_q == K_SEI) begin
                        sei_sched_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        k_d = k_q + 3'd1;
                        if (accept) begin
                            sr_load = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered: each flop is loaded with the value that belongs
    // to the next cycle's state and phase, so they line up with state_q.
    always_comb begin
        phase_d = phase_q + 4'd1;
        last_n  = (phase_d == PH_LAST);

        m2_d    = (state_d == ST_CLEAR);
        m1_d    = (state_d == ST_CLEAR) ||
                  (last_n && ((state_d == ST_IDLE) || (state_d == ST_WAIT) ||
                              (state_d == ST_SHIFT)));
        ready_d = last_n && ((state_d == ST_CLEAR) || (state_d == ST_WAIT) ||
                             ((state_d == ST_SHIFT) && (k_d != K_SEI)));
        busy_d  = (state_d != ST_IDLE) || pend_d;
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            k_q          <= '0;
            pend_q       <= 1'b0;
            sezi_sched_q <= 1'b0;
            sei_sched_q  <= 1'b0;
            m1_q         <= 1'b0;
            m2_q         <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            k_q          <= k_d;
            pend_q       <= pend_d;
            sezi_sched_q <= sezi_sched_d;
            sei_sched_q  <= sei_sched_d;
            m1_q         <= m1_d;
            m2_q         <= m2_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Strobes rise mid-cycle of phase 0, when the completed accumulator word
    // is aligned and stable, and fall mid-cycle of phase 1.
    always_ff @(negedge clk) begin
        if (reset) begin
            sezi_q <= 1'b0;
            sei_q  <= 1'b0;
        end else begin
            sezi_q <= sezi_sched_q;
            sei_q  <= sei_sched_q;
        end
    end

    p2s16 u_p2s (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (prod),
        .bit_o   (a)
    );

    assign prod_ready = ready_q;
    assign m1_sel     = m1_q;
    assign m2_sel     = m2_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sezi_en    = sezi_q;
    assign sei_en     = sei_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_accum_seq.sv
module tb_accum_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] prod;
    logic        prod_valid;
    logic        prod_ready;
    logic        a;
    logic        m1_sel;
    logic        m2_sel;
    logic        sezi_en;
    logic        sei_en;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accum_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .a          (a),
        .m1_sel     (m1_sel),
        .m2_sel     (m2_sel),
        .sezi_en    (sezi_en),
        .sei_en     (sei_en),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Reference phase: 0 in the first cycle after reset, free-running.
    logic [3:0] tb_phase = 4'd0;
    always @(posedge clk) tb_phase <= reset ? 4'd0 : tb_phase + 4'd1;

    // Model of the downstream bit-serial accumulator (16-bit circulating word).
    logic [15:0] acc = 16'h0;
    logic        cy  = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            acc <= 16'h0;
            cy  <= 1'b0;
        end else begin
            acc <= {(m2_sel ? 1'b0 : (a ^ acc[0] ^ cy)), acc[15:1]};
            cy  <= m1_sel ? 1'b0 : ((a & acc[0]) | (a & cy) | (acc[0] & cy));
        end
    end

    int          sezi_cnt = 0;
    int          sei_cnt  = 0;
    logic [15:0] sezi_word = 16'h0;
    logic [15:0] sei_word  = 16'h0;
    always @(posedge sezi_en) begin sezi_cnt++; sezi_word = acc; end
    always @(posedge sei_en)  begin sei_cnt++;  sei_word  = acc; end

    int bad_ready = 0;
    int bad_m1    = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prod_ready && tb_phase != 4'd15) bad_ready++;
            if (!busy && (m1_sel != (tb_phase == 4'd15))) bad_m1++;
        end
    end

    logic [15:0] tab [8];

    // Runs one frame from a negedge. stall_idx/stall_n drop prod_valid for
    // stall_n cycles once stall_idx products are accepted; restart_idx pulses
    // start 3 cycles into that product; reset_idx pulses reset 5 cycles in.
    task automatic run_frame(input int stall_idx, input int stall_n, input int restart_idx,
                             input int reset_idx, output int lat, output bit aborted);
        int idx, cyc, clr_cyc, since_acc, stall_left;
        bit fin, acc_now, restarted;
        idx = 0; cyc = 0; clr_cyc = -1; since_acc = 0; stall_left = stall_n;
        fin = 1'b0; restarted = 1'b0; lat = -1; aborted = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        while (!fin && cyc < 1000) begin
            cyc++;
            if (m2_sel && clr_cyc < 0) clr_cyc = cyc;
            if (done) begin
                lat = cyc - clr_cyc;
                fin = 1'b1;
            end
            if (reset_idx >= 0 && idx == reset_idx && since_acc == 5) begin
                reset = 1'b1; prod_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                checks++;
                if ({a, m1_sel, m2_sel, sezi_en, sei_en, prod_ready, busy, done} !== 8'h00) begin
                    errors++;
                    $display("FAIL outputs_after_midreset: got %b expected 00000000",
                             {a, m1_sel, m2_sel, sezi_en, sei_en, prod_ready, busy, done});
                end
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                if (restart_idx >= 0 && idx == restart_idx && since_acc == 3 && !restarted) begin
                    start = 1'b1;
                    restarted = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (stall_left > 0 && idx == stall_idx) begin
                    prod_valid = 1'b0;
                    stall_left--;
                end else begin
                    prod_valid = 1'b1;
                end
                prod = (idx < 8) ? tab[idx] : 16'h0;
                acc_now = prod_valid && prod_ready;
                @(posedge clk);
                if (acc_now) begin idx++; since_acc = 0; end
                else since_acc++;
                @(negedge clk);
                if (start) begin
                    start = 1'b0;
                    checks++;
                    if (busy !== 1'b1 || m2_sel !== 1'b0) begin
                        errors++;
                        $display("FAIL restart_ignored: got busy=%b m2=%b expected busy=1 m2=0",
                                 busy, m2_sel);
                    end
                end
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL frame_timeout: got no done within %0d cycles expected done", cyc);
        end
    endtask

    task automatic check_frame(input string name, input int lat, input int exp_lat,
                               input int s0, input int i0,
                               input logic [15:0] exp_zw, input logic [15:0] exp_w);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (sezi_cnt - s0 != 1 || sei_cnt - i0 != 1) begin
            errors++;
            $display("FAIL %s_strobe_count: got sezi=%0d sei=%0d expected 1 1",
                     name, sezi_cnt - s0, sei_cnt - i0);
        end
        checks++;
        if (sezi_word !== exp_zw || sezi_word[15:1] !== exp_zw[15:1]) begin
            errors++;
            $display("FAIL %s_sezi: got word %h sezi %h expected word %h sezi %h",
                     name, sezi_word, sezi_word[15:1], exp_zw, exp_zw[15:1]);
        end
        checks++;
        if (sei_word !== exp_w) begin
            errors++;
            $display("FAIL %s_sei: got word %h sei %h expected word %h sei %h",
                     name, sei_word, sei_word[15:1], exp_w, exp_w[15:1]);
        end
    endtask

    task automatic load_sum_tab();
        for (int i = 0; i < 6; i++) tab[i] = 16'h0010;
        tab[6] = 16'h0100;
        tab[7] = 16'h0100;
    endtask

    task automatic test_reset();
        int m1_hi;
        reset = 1'b1; start = 1'b0; prod = 16'h0; prod_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({a, m1_sel, m2_sel, sezi_en, sei_en, prod_ready, busy, done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {a, m1_sel, m2_sel, sezi_en, sei_en, prod_ready, busy, done});
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        m1_hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (m1_sel) begin
                m1_hi++;
                checks++;
                if (tb_phase != 4'd15) begin
                    errors++;
                    $display("FAIL idle_m1_phase: got phase %0d expected 15", tb_phase);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (m1_hi != 2) begin
            errors++;
            $display("FAIL idle_m1_count: got %0d expected 2", m1_hi);
        end
    endtask

    task automatic test_sum();
        int lat, s0, i0; bit ab;
        load_sum_tab();
        s0 = sezi_cnt; i0 = sei_cnt;
        run_frame(-1, 0, -1, -1, lat, ab);
        check_frame("sum", lat, 144, s0, i0, 16'h0060, 16'h0260);
    endtask

    task automatic test_wrap();
        int lat, s0, i0; bit ab;
        for (int i = 0; i < 6; i++) tab[i] = 16'hFFFF;
        tab[6] = 16'h8000;
        tab[7] = 16'h8000;
        s0 = sezi_cnt; i0 = sei_cnt;
        run_frame(-1, 0, -1, -1, lat, ab);
        check_frame("wrap", lat, 144, s0, i0, 16'hFFFA, 16'hFFFA);
    endtask

    task automatic test_stall();
        int lat, s0, i0, br0; bit ab;
        load_sum_tab();
        s0 = sezi_cnt; i0 = sei_cnt; br0 = bad_ready;
        // 40 idle cycles push the third product out by two 16-cycle passes.
        run_frame(2, 40, -1, -1, lat, ab);
        check_frame("stall", lat, 176, s0, i0, 16'h0060, 16'h0260);
        checks++;
        if (bad_ready != br0) begin
            errors++;
            $display("FAIL ready_phase: got %0d off-phase ready cycles expected 0", bad_ready - br0);
        end
    endtask

    task automatic test_restart();
        int lat, s0, i0; bit ab;
        load_sum_tab();
        s0 = sezi_cnt; i0 = sei_cnt;
        run_frame(-1, 0, 3, -1, lat, ab);
        check_frame("restart", lat, 144, s0, i0, 16'h0060, 16'h0260);
        repeat (40) @(negedge clk);
        checks++;
        if (sezi_cnt - s0 != 1 || sei_cnt - i0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_extra: got sezi=%0d sei=%0d busy=%b expected 1 1 0",
                     sezi_cnt - s0, sei_cnt - i0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, s0, i0; bit ab;
        load_sum_tab();
        s0 = sezi_cnt; i0 = sei_cnt;
        run_frame(-1, 0, -1, 4, lat, ab);
        checks++;
        if (ab !== 1'b1) begin
            errors++;
            $display("FAIL midreset_applied: got %b expected 1", ab);
        end
        repeat (150) @(negedge clk);
        checks++;
        if (sezi_cnt != s0 || sei_cnt != i0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_strobes: got sezi=%0d sei=%0d busy=%b expected 0 0 0",
                     sezi_cnt - s0, sei_cnt - i0, busy);
        end
        checks++;
        if (bad_m1 != 0) begin
            errors++;
            $display("FAIL idle_m1_pattern: got %0d bad cycles expected 0", bad_m1);
        end
        s0 = sezi_cnt; i0 = sei_cnt;
        run_frame(-1, 0, -1, -1, lat, ab);
        check_frame("after_reset", lat, 144, s0, i0, 16'h0060, 16'h0260);
    endtask

    task automatic test_back_to_back();
        int lat, s0, i0; bit ab;
        load_sum_tab();
        s0 = sezi_cnt; i0 = sei_cnt;
        run_frame(-1, 0, -1, -1, lat, ab);
        check_frame("b2b_first", lat, 144, s0, i0, 16'h0060, 16'h0260);
        // 1+2+3+4+5+6 = 0x15; + 0x0100 + 0x0001 = 0x116
        for (int i = 0; i < 6; i++) tab[i] = 16'(i + 1);
        tab[6] = 16'h0100;
        tab[7] = 16'h0001;
        s0 = sezi_cnt; i0 = sei_cnt;
        run_frame(-1, 0, -1, -1, lat, ab);
        check_frame("b2b_second", lat, 144, s0, i0, 16'h0015, 16'h0116);
    endtask

    initial begin
        test_reset();
        test_sum();
        test_wrap();
        test_stall();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

endmodule
